// File: rtl/adc_scan_seq_if.sv
// SPI-controller link of the ADC scan sequencer: command byte out, received byte back.
interface adc_scan_seq_if;
  logic [7:0] spi_data_out;
  logic       spi_trigger_out;
  logic [7:0] spi_data_in;
  logic       spi_valid_in;

  modport master (output spi_data_out, spi_trigger_out, input spi_data_in, spi_valid_in);
  modport slave  (input spi_data_out, spi_trigger_out, output spi_data_in, spi_valid_in);
endinterface

// File: rtl/adc_scan_seq.sv
// Periodic multi-channel ADC scanner: issues a 3-byte SPI transfer per masked channel
// (lowest first) and emits one 10-bit sample per channel.
module adc_scan_seq #(
  parameter int SAMPLE_PERIOD  = 10000,
  parameter int NUM_CHANNELS   = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           enable_in,
  input  logic [7:0]     channel_mask_in,
  adc_scan_seq_if.master spi,
  output logic [9:0]     sample_out,
  output logic [2:0]     channel_out,
  output logic           sample_valid_out,
  output logic           scan_done_out,
  output logic           overrun_out,
  output logic           timeout_out,
  output logic           busy_out
);
  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] CH_LIMIT = 8'((1 << NUM_CHANNELS) - 1);

  typedef enum logic [2:0] {IDLE, SELECT, SEND, WAIT, EMIT} state_t;

  state_t        state, state_d;
  logic [PW-1:0] period_cnt;
  logic [TW-1:0] wait_cnt;
  logic [7:0]    mask_q;
  logic [7:0]    tx_data;
  logic [2:0]    ch_q;
  logic [2:0]    low_ch;
  logic [1:0]    idx_q;
  logic [1:0]    rx1_lo;
  logic          stop_q;
  logic          stop;
  logic          has_ch;
  logic          scan_start;
  logic          wait_expired;

  function automatic logic [7:0] tx_byte(input logic [1:0] idx, input logic [2:0] ch);
    case (idx)
      2'd0:    return 8'h01;
      2'd1:    return {1'b1, ch, 4'b0000};
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      period_cnt <= '0;
    end else if (!enable_in || period_cnt == PW'(SAMPLE_PERIOD - 1)) begin
      // NOTE: sequential state always uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  assign scan_start   = enable_in && (period_cnt == PW'(SAMPLE_PERIOD - 1));
  assign wait_expired = (wait_cnt == TW'(TIMEOUT_CYCLES));
  // Once enable drops mid-scan the current channel finishes, then the scan is abandoned.
  assign stop         = stop_q || !enable_in;
  assign has_ch       = |mask_q;

  always_comb begin
    low_ch = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) low_ch = 3'(i);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state;
    case (state)
      IDLE:    if (scan_start) state_d = SELECT;
      SELECT:  state_d = (stop || !has_ch) ? IDLE : SEND;
      SEND:    state_d = WAIT;
      WAIT: begin
        if (spi.spi_valid_in)  state_d = (idx_q == 2'd2) ? EMIT : SEND;
        else if (wait_expired) state_d = IDLE;
      end
      EMIT:    state_d = stop ? IDLE : SELECT;
      default: state_d = IDLE;
    endcase
  end

  assign busy_out            = (state != IDLE);
  assign spi.spi_trigger_out = (state == SEND);
  assign spi.spi_data_out    = tx_data;
  assign sample_valid_out    = (state == EMIT);
  assign scan_done_out       = (state == SELECT) && !stop && !has_ch;
  assign overrun_out         = scan_start && (state != IDLE);
  assign timeout_out         = (state == WAIT) && !spi.spi_valid_in && wait_expired;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wait_cnt    <= '0;
      mask_q      <= '0;
      tx_data     <= '0;
      ch_q        <= '0;
      idx_q       <= '0;
      rx1_lo      <= '0;
      stop_q      <= 1'b0;
      sample_out  <= '0;
      channel_out <= '0;
    end else begin
      if (state == IDLE)  stop_q <= 1'b0;
      else if (!enable_in) stop_q <= 1'b1;

      case (state)
        IDLE: if (scan_start) mask_q <= channel_mask_in & CH_LIMIT;
        SELECT: begin
          if (!stop && has_ch) begin
            ch_q           <= low_ch;
            mask_q[low_ch] <= 1'b0;
            idx_q          <= 2'd0;
            tx_data        <= tx_byte(2'd0, low_ch);
          end
        end
        SEND: wait_cnt <= '0;
        WAIT: begin
          if (spi.spi_valid_in) begin
            if (idx_q == 2'd1) rx1_lo <= spi.spi_data_in[1:0];
            if (idx_q == 2'd2) begin
              sample_out  <= {rx1_lo, spi.spi_data_in};
              channel_out <= ch_q;
            end else begin
              idx_q   <= idx_q + 2'd1;
              tx_data <= tx_byte(idx_q + 2'd1, ch_q);
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_scan_seq.sv
// Directed bench for adc_scan_seq: table of single-scan vectors plus hand-written
// sequences for timeout, overrun, enable drop and mid-transfer reset.
module tb_adc_scan_seq;
  localparam int PERIOD = 20;
  localparam int TMO    = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] mask = 8'h00;
  logic [9:0] sample;
  logic [2:0] channel;
  logic       sample_valid, scan_done, overrun, timeout, busy;

  adc_scan_seq_if spi ();

  adc_scan_seq #(.SAMPLE_PERIOD(PERIOD), .NUM_CHANNELS(6), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk), .rst_in(rst_n), .enable_in(enable), .channel_mask_in(mask), .spi(spi),
    .sample_out(sample), .channel_out(channel), .sample_valid_out(sample_valid),
    .scan_done_out(scan_done), .overrun_out(overrun), .timeout_out(timeout), .busy_out(busy));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI controller model controls
  int         lat = 1;
  logic [7:0] resp1 = 8'h00, resp2 = 8'h00;
  bit         stall = 1'b0;
  int         stray_req = 0;

  // Observation logs (written only by the model / monitor)
  logic [7:0] trig_q[$];
  logic [2:0] samp_ch_q[$];
  logic [9:0] samp_val_q[$];
  int         samp_lat_q[$];
  int         samp_cyc_q[$];
  int         done_q[$];
  int         overrun_n = 0, timeout_n = 0;
  int         last_trig_cyc = 0, last_vin_cyc = 0, timeout_cyc = 0;

  initial begin
    int pend;
    int stray_ack;
    logic [7:0] pend_data;
    pend = 0; stray_ack = 0; pend_data = 8'h00;
    spi.spi_valid_in = 1'b0;
    spi.spi_data_in  = 8'h00;
    forever begin
      @(negedge clk);
      spi.spi_valid_in = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            spi.spi_data_in  = pend_data;
            spi.spi_valid_in = 1'b1;
            last_vin_cyc     = cyc;
          end
        end
        if (stray_req != stray_ack) begin
          stray_ack        = stray_req;
          spi.spi_data_in  = 8'hFF;
          spi.spi_valid_in = 1'b1;
        end
        if (spi.spi_trigger_out) begin
          trig_q.push_back(spi.spi_data_out);
          last_trig_cyc = cyc;
          pend_data = (spi.spi_data_out == 8'h01) ? 8'h00 :
                      (spi.spi_data_out == 8'h00) ? resp2 : resp1;
          if (!(stall && spi.spi_data_out == 8'h00)) pend = lat;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (sample_valid) begin
        samp_ch_q.push_back(channel);
        samp_val_q.push_back(sample);
        samp_lat_q.push_back(cyc - last_vin_cyc);
        samp_cyc_q.push_back(cyc);
      end
      if (scan_done) done_q.push_back(cyc);
      if (overrun) overrun_n++;
      if (timeout) begin
        timeout_n++;
        timeout_cyc = cyc;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst_n  = 1'b0;
    step();
    step();
    rst_n  = 1'b1;
    step();
  endtask

  typedef struct {
    logic [7:0] mask;
    logic [7:0] r1, r2;
    int         n_samp;
    logic [9:0] val;
    logic [2:0] first_ch, last_ch;
    logic [7:0] first_b1, last_b1;
  } vec_t;

  task automatic run_vec(input vec_t v, input int k);
    int s0, d0, t0, o0, n;
    do_reset();
    resp1 = v.r1; resp2 = v.r2; lat = 1; stall = 1'b0; mask = v.mask;
    s0 = samp_val_q.size(); d0 = done_q.size(); t0 = trig_q.size(); o0 = overrun_n;
    enable = 1'b1;
    for (int i = 0; i < 80 && done_q.size() == d0; i++) step();
    enable = 1'b0;
    repeat (3) step();
    n = v.n_samp;
    check($sformatf("v%0d done_count", k), done_q.size() - d0, 1);
    check($sformatf("v%0d samples", k), samp_val_q.size() - s0, n);
    check($sformatf("v%0d triggers", k), trig_q.size() - t0, 3 * n);
    check($sformatf("v%0d overruns", k), overrun_n - o0, 0);
    check($sformatf("v%0d busy_idle", k), busy, 0);
    if (n > 0 && samp_val_q.size() - s0 == n && trig_q.size() - t0 == 3 * n) begin
      check($sformatf("v%0d first_val", k), samp_val_q[s0], v.val);
      check($sformatf("v%0d first_ch", k), samp_ch_q[s0], v.first_ch);
      check($sformatf("v%0d last_ch", k), samp_ch_q[s0 + n - 1], v.last_ch);
      check($sformatf("v%0d byte0", k), trig_q[t0], 8'h01);
      check($sformatf("v%0d byte1_first", k), trig_q[t0 + 1], v.first_b1);
      check($sformatf("v%0d byte2", k), trig_q[t0 + 2], 8'h00);
      check($sformatf("v%0d byte1_last", k), trig_q[t0 + 3 * n - 2], v.last_b1);
      check($sformatf("v%0d sample_latency", k), samp_lat_q[s0 + n - 1], 1);
      check($sformatf("v%0d done_after_sample", k), done_q[d0] - samp_cyc_q[s0 + n - 1], 1);
      check($sformatf("v%0d sample_hold", k), sample, v.val);
      check($sformatf("v%0d channel_hold", k), channel, v.last_ch);
      check($sformatf("v%0d data_hold", k), spi.spi_data_out, 8'h00);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int s0, d0, t0, o0, x0;
    // channel byte is {1, ch, 4'b0}: ch0 -> 80, ch1 -> 90, ch2 -> A0, ch5 -> D0
    vecs[0] = '{8'h05, 8'h02, 8'h5A, 2, 10'h25A, 3'd0, 3'd2, 8'h80, 8'hA0};
    vecs[1] = '{8'h06, 8'hFE, 8'h34, 2, 10'h234, 3'd1, 3'd2, 8'h90, 8'hA0};
    vecs[2] = '{8'h20, 8'h01, 8'h00, 1, 10'h100, 3'd5, 3'd5, 8'hD0, 8'hD0};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 0, 10'h000, 3'd0, 3'd0, 8'h00, 8'h00};
    vecs[4] = '{8'hC0, 8'h00, 8'h00, 0, 10'h000, 3'd0, 3'd0, 8'h00, 8'h00};
    vecs[5] = '{8'h21, 8'h03, 8'hFF, 2, 10'h3FF, 3'd0, 3'd5, 8'h80, 8'hD0};

    // Reset state
    step();
    check("reset_outputs",
          {22'd0, busy, sample_valid, scan_done, overrun, timeout, spi.spi_trigger_out, 3'd0, channel},
          32'd0);
    check("reset_sample", sample, 10'h000);
    check("reset_spi_data", spi.spi_data_out, 8'h00);
    rst_n = 1'b1;
    step();

    // Stray valid while idle is ignored
    s0 = samp_val_q.size();
    stray_req++;
    repeat (3) step();
    check("stray_no_sample", samp_val_q.size() - s0, 0);
    check("stray_busy", busy, 0);

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

    // Empty mask: scan_done every period, no trigger
    do_reset();
    mask = 8'h00; lat = 1;
    d0 = done_q.size(); t0 = trig_q.size();
    enable = 1'b1;
    for (int i = 0; i < 100 && done_q.size() < d0 + 3; i++) step();
    enable = 1'b0;
    check("empty_done_count", done_q.size() - d0, 3);
    if (done_q.size() >= d0 + 3) begin
      check("empty_interval_1", done_q[d0 + 1] - done_q[d0], PERIOD);
      check("empty_interval_2", done_q[d0 + 2] - done_q[d0 + 1], PERIOD);
    end
    check("empty_no_trigger", trig_q.size() - t0, 0);

    // Timeout on stalled third byte
    do_reset();
    mask = 8'h01; resp1 = 8'h02; resp2 = 8'h5A; lat = 1; stall = 1'b1;
    s0 = samp_val_q.size(); d0 = done_q.size(); x0 = timeout_n;
    enable = 1'b1;
    for (int i = 0; i < 100 && timeout_n == x0; i++) step();
    check("timeout_seen", timeout_n - x0, 1);
    check("timeout_byte", trig_q[trig_q.size() - 1], 8'h00);
    check("timeout_delay", timeout_cyc - last_trig_cyc, TMO + 1);
    step();
    check("timeout_busy_low", busy, 0);
    check("timeout_pulse_width", timeout_n - x0, 1);
    enable = 1'b0; stall = 1'b0;
    step();
    check("timeout_no_sample", samp_val_q.size() - s0, 0);
    check("timeout_no_done", done_q.size() - d0, 0);

    // Slow SPI: scan outlasts the period, starts are dropped
    do_reset();
    mask = 8'h01; resp1 = 8'h02; resp2 = 8'h5A; lat = 10;
    s0 = samp_val_q.size(); d0 = done_q.size(); o0 = overrun_n;
    enable = 1'b1;
    for (int i = 0; i < 200 && samp_val_q.size() < s0 + 2; i++) step();
    enable = 1'b0;
    repeat (3) step();
    check("ovr_count", overrun_n - o0, 2);
    check("ovr_samples", samp_val_q.size() - s0, 2);
    check("ovr_done", done_q.size() - d0, 1);
    if (samp_val_q.size() >= s0 + 2) begin
      check("ovr_val0", {3'd0, samp_ch_q[s0], samp_val_q[s0]}, {3'd0, 3'd0, 10'h25A});
      check("ovr_val1", {3'd0, samp_ch_q[s0 + 1], samp_val_q[s0 + 1]}, {3'd0, 3'd0, 10'h25A});
    end

    // Enable dropped during byte 1 of ch0
    do_reset();
    mask = 8'h03; resp1 = 8'h02; resp2 = 8'h5A; lat = 1;
    s0 = samp_val_q.size(); d0 = done_q.size(); t0 = trig_q.size();
    enable = 1'b1;
    for (int i = 0; i < 60 && trig_q.size() < t0 + 2; i++) step();
    enable = 1'b0;
    repeat (20) step();
    check("drop_samples", samp_val_q.size() - s0, 1);
    if (samp_val_q.size() > s0) check("drop_sample", {samp_ch_q[s0], samp_val_q[s0]}, {3'd0, 10'h25A});
    check("drop_triggers", trig_q.size() - t0, 3);
    check("drop_no_done", done_q.size() - d0, 0);
    check("drop_busy", busy, 0);

    // Reset during WAIT of ch1, then restart from lowest channel
    do_reset();
    mask = 8'h03; resp1 = 8'h02; resp2 = 8'h5A; lat = 5;
    t0 = trig_q.size();
    enable = 1'b1;
    for (int i = 0; i < 100 && trig_q.size() < t0 + 5; i++) step();
    if (trig_q.size() >= t0 + 5) check("rst_ch1_byte1", trig_q[t0 + 4], 8'h90);
    else check("rst_ch1_reached", trig_q.size() - t0, 5);
    step();
    step();
    check("rst_busy_before", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_outputs",
          {22'd0, busy, sample_valid, scan_done, overrun, timeout, spi.spi_trigger_out, 3'd0, channel},
          32'd0);
    check("rst_async_data", {14'd0, sample, spi.spi_data_out}, 32'd0);
    step();
    rst_n = 1'b1;
    s0 = samp_val_q.size(); t0 = trig_q.size();
    for (int i = 0; i < 80 && samp_val_q.size() == s0; i++) step();
    enable = 1'b0;
    check("rst_restart_sample", samp_val_q.size() - s0, 1);
    if (samp_val_q.size() > s0) check("rst_restart_ch", samp_ch_q[s0], 3'd0);
    if (trig_q.size() >= t0 + 2) check("rst_restart_byte1", trig_q[t0 + 1], 8'h80);
    else check("rst_restart_triggers", trig_q.size() - t0, 2);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
